keypad_scan_ctrl: RTL and testbench
===================================

Name: keypad_scan_ctrl

Overview:
- Scans the 4x4 matrix keypad on the GPIO header: drives one row at a time, samples the columns, debounces and reports presses.
- Emits one single-cycle key event with a 4-bit position code.
- Gives the calculator state machine a clean key_press/key_code source in place of raw GPIO pins.
- Runs on the system clock; scan timing comes from an external scan_tick strobe (the 500 Hz enable).

Parameters:
- DEBOUNCE_TICKS, 4: consecutive ticks a key must read stably pressed before it is reported (legal range 1..15).
- RELEASE_TICKS, 2: consecutive ticks with all columns high before the key counts as released (legal range 1..15).
- REPEAT_TICKS, 50: auto-repeat period in ticks; used only when KEYPAD_AUTOREPEAT_EN is defined.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- scan_tick  in  1  one-clk-wide strobe; all scan/debounce timing advances only on it
- col_n  in  4  keypad columns, active-low, externally pulled up, asynchronous
- row_n  out  4  keypad row drive, active-low, exactly one bit low at all times
- key_valid  out  1  one-clk pulse per accepted key event
- key_code  out  4  {row_idx[1:0], col_idx[1:0]}; valid with key_valid, holds until next event
- key_held  out  1  high from the report cycle until release is confirmed

Behaviour:
- Reset values: row_n=4'b1110, key_valid=0, key_code=0, key_held=0, state SCAN, row_idx=0, counters=0.
- col_n passes through a 2-flop synchronizer before any use. FSM reads are taken only on clk edges where scan_tick=1.
- State SCAN:
  - On a tick with all synced cols high, row_idx increments mod 4 and row_n updates on the same edge.
  - On a tick with any col low, latch row_idx and col_idx (lowest low column wins), clear the counter, go to DEBOUNCE. row_n stays frozen.
- State DEBOUNCE:
  - On each tick, if the latched column is still low, increment the counter. When the counter reaches DEBOUNCE_TICKS-1, go to REPORT.
  - If the latched column reads high, return to SCAN with row_idx+1 and emit no event.
- State REPORT:
  - Lasts exactly one clk, tick not required.
  - key_valid=1, key_code={row,col}, key_held=1. Then go to WAIT_RELEASE.
- State WAIT_RELEASE:
  - Row stays frozen.
  - On a tick with all cols high, increment the release counter; any low col clears it.
  - When the counter reaches RELEASE_TICKS-1, drop key_held and return to SCAN with row_idx+1.
- Latency: a stable press is reported on the clk after the DEBOUNCE_TICKS-th qualifying tick.
- Multiple keys:
  - Same row: lowest column index wins.
  - Different rows: the first row scanned wins.
  - Extra keys pressed during WAIT_RELEASE are ignored; release requires all columns high.
- A scan_tick that arrives during REPORT is ignored.
- Synchronous reset at any point, including mid-debounce or in REPORT, forces reset values on the next edge. No key_valid is emitted afterward for the interrupted press.
- The latched col_idx encoding is the binary index 0..3.

Optional Feature:
- KEYPAD_AUTOREPEAT_EN defined:
  - In WAIT_RELEASE, while the latched key stays low, a repeat counter counts ticks.
  - Every REPEAT_TICKS ticks it re-emits key_valid for one clk with the same key_code.
  - The counter resets on any release tick.
- Not defined: exactly one key_valid per press, and REPEAT_TICKS is unused.

Decomposition:
- Package keypad_pkg holds:
  - the state encoding (SCAN, DEBOUNCE, REPORT, WAIT_RELEASE) as a 2-bit typedef;
  - width constants (ROWS=4, COLS=4, code width 4);
  - the code-to-legend map constants for the calculator FSM: 0:'1' 1:'2' 2:'3' 3:'A' / 4:'4' 5:'5' 6:'6' 7:'B' / 8:'7' 9:'8' 10:'9' 11:'C' / 12:'*' 13:'0' 14:'#' 15:'D'.
- One natural sub-module: keypad_col_sync, a 4-bit two-flop synchronizer with reset value 4'b1111.

Test Plan:
- Press at row 2, col 1 held 8 ticks, DEBOUNCE_TICKS=4 -> exactly one key_valid with key_code=9. key_held stays high until 2 release ticks pass, then row_n resumes at 4'b0111.
- Bounce: col 1 low for 2 ticks then high while row 0 is driven -> no key_valid, return to SCAN, row_n advances to 4'b1101.
- Row 0 with cols 2 and 3 low together -> key_code=2. Pressing row 3 col 0 during the hold -> no second event.
- Reset asserted on the 3rd debounce tick, then key kept low -> outputs at reset values next clk. A fresh debounce from row 0 gives key_valid one event after 4 more qualifying ticks.
- Idle with 5 ticks, no keys -> row_n sequence 1110, 1101, 1011, 0111, 1110. key_valid stays 0.
- KEYPAD_AUTOREPEAT_EN, REPEAT_TICKS=5, key held 16 ticks after the report -> 1 initial event plus 3 repeats, all with the same key_code.

Source files
------------

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared scan states, keypad geometry and key-code legend for the keypad scanner
package keypad_pkg;
  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int CODE_W = 4;
  typedef enum logic [1:0] {SCAN, DEBOUNCE, REPORT, WAIT_RELEASE} key_state_t;
  localparam logic [7:0] KEY_LEGEND [16] = '{
    "1", "2", "3", "A",
    "4", "5", "6", "B",
    "7", "8", "9", "C",
    "*", "0", "#", "D"
  };
  function automatic logic [1:0] lowest_low(input logic [COLS-1:0] c);
    return !c[0] ? 2'd0 : !c[1] ? 2'd1 : !c[2] ? 2'd2 : 2'd3;
  endfunction
  function automatic logic [7:0] key_legend(input logic [CODE_W-1:0] code);
    return KEY_LEGEND[code];
  endfunction
endpackage

// File: rtl/keypad_col_sync.sv
// keypad_col_sync: two-flop synchronizer for the asynchronous active-low keypad columns
module keypad_col_sync
  import keypad_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic [COLS-1:0] d,
  output logic [COLS-1:0] q
);
  logic [COLS-1:0] meta;
  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: 4x4 keypad row scanner with debounce and key events; KEYPAD_AUTOREPEAT_EN adds auto-repeat
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = 4,
  parameter int RELEASE_TICKS  = 2,
  parameter int REPEAT_TICKS   = 50
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              scan_tick,
  input  logic [COLS-1:0]   col_n,
  output logic [ROWS-1:0]   row_n,
  output logic              key_valid,
  output logic [CODE_W-1:0] key_code,
  output logic              key_held
);
  if (DEBOUNCE_TICKS < 1 || DEBOUNCE_TICKS > 15 || RELEASE_TICKS < 1 || RELEASE_TICKS > 15 || REPEAT_TICKS < 1) begin : g_bad_params
    $error("keypad_scan_ctrl: tick parameter out of range");
  end
  logic [COLS-1:0] col_s;
  logic [1:0] row_idx, col_idx, low_col;
  logic [3:0] cnt;
  logic all_high;
  key_state_t state;
`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int RPT_W = $clog2(REPEAT_TICKS + 1);
  logic [RPT_W-1:0] rep_cnt;
`endif
  keypad_col_sync u_col_sync (.clk(clk), .reset(reset), .d(col_n), .q(col_s));
  assign all_high = &col_s;
  assign low_col = lowest_low(col_s);
  assign row_n = ~(4'b0001 << row_idx);
  // row_idx is frozen from detection until the key is dropped, so it doubles as the latched row
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= SCAN;
      row_idx   <= '0;
      col_idx   <= '0;
      cnt       <= '0;
      key_valid <= 1'b0;
      key_code  <= '0;
      key_held  <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_cnt   <= '0;
`endif
    end else begin
      key_valid <= 1'b0;
      case (state)
        SCAN: if (scan_tick) begin
          if (all_high) row_idx <= row_idx + 1'b1;
          else begin
            col_idx <= low_col;
            cnt     <= '0;
            state   <= DEBOUNCE_TICKS == 1 ? REPORT : DEBOUNCE;
            if (DEBOUNCE_TICKS == 1) begin
              key_valid <= 1'b1;
              key_held  <= 1'b1;
              key_code  <= {row_idx, low_col};
            end
          end
        end
        DEBOUNCE: if (scan_tick) begin
          if (col_s[col_idx]) begin
            state   <= SCAN;
            row_idx <= row_idx + 1'b1;
          end else if (cnt == 4'(DEBOUNCE_TICKS - 2)) begin
            state     <= REPORT;
            key_valid <= 1'b1;
            key_held  <= 1'b1;
            key_code  <= {row_idx, col_idx};
          end else cnt <= cnt + 1'b1;
        end
        REPORT: begin
          state <= WAIT_RELEASE;
          cnt   <= '0;
`ifdef KEYPAD_AUTOREPEAT_EN
          rep_cnt <= '0;
`endif
        end
        WAIT_RELEASE: if (scan_tick) begin
          if (!all_high) cnt <= '0;
          else if (cnt == 4'(RELEASE_TICKS - 1)) begin
            state    <= SCAN;
            key_held <= 1'b0;
            row_idx  <= row_idx + 1'b1;
          end else cnt <= cnt + 1'b1;
`ifdef KEYPAD_AUTOREPEAT_EN
          if (col_s[col_idx]) rep_cnt <= '0;
          else if (rep_cnt == RPT_W'(REPEAT_TICKS - 1)) begin
            rep_cnt   <= '0;
            key_valid <= 1'b1;
          end else rep_cnt <= rep_cnt + 1'b1;
`endif
        end
      endcase
    end
  end
endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb_keypad_scan_ctrl: randomized keypad stimulus with an event scoreboard; honours KEYPAD_AUTOREPEAT_EN
module tb_keypad_scan_ctrl;
  localparam int DEB = 4;
  localparam int REL = 2;
`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int RPT = 5;
`else
  localparam int RPT = 50;
`endif
  logic clk = 1'b0, reset = 1'b1, scan_tick = 1'b0;
  logic [3:0] col_n, row_n, key_code;
  logic key_valid, key_held;
  logic [3:0] keys [4];
  int checks = 0, passes = 0, cyc = 0;
  typedef struct {int code; int cyc;} ev_t;
  ev_t exp_q[$];
  int m_row, m_phase, m_lr, m_lc, m_run, m_rel, m_rep;
  bit m_held;

  keypad_scan_ctrl #(.DEBOUNCE_TICKS(DEB), .RELEASE_TICKS(REL), .REPEAT_TICKS(RPT)) dut (
    .clk(clk), .reset(reset), .scan_tick(scan_tick), .col_n(col_n),
    .row_n(row_n), .key_valid(key_valid), .key_code(key_code), .key_held(key_held)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // physical keypad: a pressed key shorts its column to whichever row is driven low
  always_comb begin
    col_n = 4'hF;
    for (int r = 0; r < 4; r++) if (!row_n[r]) col_n = col_n & ~keys[r];
  end

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  task automatic emit();
    ev_t e;
    e.code = m_lr * 4 + m_lc;
    e.cyc  = cyc + 1;
    exp_q.push_back(e);
  endtask

  task automatic model_reset();
    m_row = 0; m_phase = 0; m_lr = 0; m_lc = 0; m_run = 0; m_rel = 0; m_rep = 0; m_held = 0;
  endtask

  task automatic accept();
    emit();
    m_phase = 2; m_held = 1; m_rel = 0; m_rep = 0;
  endtask

  // tick-level reference: counts consecutive pressed / released ticks on the row being looked at
  task automatic model_tick();
    logic [3:0] c;
    c = keys[m_row];
    if (m_phase == 0) begin
      if (c == 0) m_row = (m_row + 1) % 4;
      else begin
        m_lr = m_row; m_lc = 0;
        while (!c[m_lc]) m_lc++;
        m_run = 1; m_phase = 1;
        if (m_run == DEB) accept();
      end
    end else if (m_phase == 1) begin
      if (c[m_lc]) begin
        m_run++;
        if (m_run == DEB) accept();
      end else begin
        m_phase = 0; m_row = (m_row + 1) % 4;
      end
    end else if (c == 0) begin
      m_rep = 0; m_rel++;
      if (m_rel == REL) begin
        m_held = 0; m_phase = 0; m_row = (m_row + 1) % 4;
      end
    end else begin
      m_rel = 0;
`ifdef KEYPAD_AUTOREPEAT_EN
      if (c[m_lc]) begin
        m_rep++;
        if (m_rep == RPT) begin emit(); m_rep = 0; end
      end else m_rep = 0;
`endif
    end
  endtask

  task automatic tick(input bit rst = 0);
    logic [3:0] er;
    repeat ($urandom_range(3, 5)) @(negedge clk);
    if (rst) model_reset(); else model_tick();
    scan_tick = 1'b1;
    reset = rst;
    @(negedge clk);
    scan_tick = 1'b0;
    reset = 1'b0;
    er = ~(4'b0001 << m_row);
    check("row_n", int'(row_n), int'(er));
    check("key_held", int'(key_held), int'(m_held));
    if (rst) begin
      check("reset_key_valid", int'(key_valid), 0);
      check("reset_key_code", int'(key_code), 0);
    end
  endtask

  task automatic clear_keys();
    for (int r = 0; r < 4; r++) keys[r] = 4'h0;
  endtask

  always @(negedge clk) begin
    ev_t e;
    if (!reset && key_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_event: key_code %0d at cycle %0d, expected no event", key_code, cyc);
      end else begin
        e = exp_q.pop_front();
        check("event_code", int'(key_code), e.code);
        check("event_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    clear_keys();
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("init_row_n", int'(row_n), 4'b1110);
    check("init_key_valid", int'(key_valid), 0);
    check("init_key_code", int'(key_code), 0);
    check("init_key_held", int'(key_held), 0);
    repeat (5) tick();
    keys[2] = 4'b0010;
    repeat (12) tick();
    keys[2] = 4'h0;
    repeat (3) tick();
    for (int i = 0; i < 4 && m_row != 0; i++) tick();
    keys[0] = 4'b0010;
    repeat (2) tick();
    keys[0] = 4'h0;
    tick();
    keys[0] = 4'b1100;
    for (int i = 0; i < 10 && !m_held; i++) tick();
    keys[3] = 4'b0001;
    repeat (3) tick();
    clear_keys();
    repeat (3) tick();
    for (int i = 0; i < 4 && m_row != 0; i++) tick();
    keys[0] = 4'b0001;
    for (int i = 0; i < 6 && !(m_phase == 1 && m_run == 2); i++) tick();
    tick(1);
    repeat (6) tick();
    clear_keys();
    repeat (3) tick();
    repeat (30) begin
      int n;
      n = $urandom_range(0, 2);
      for (int k = 0; k < n; k++) keys[$urandom_range(0, 3)][$urandom_range(0, 3)] = 1'b1;
      repeat ($urandom_range(1, 12)) tick();
      if ($urandom_range(0, 1) == 1) clear_keys();
      else keys[$urandom_range(0, 3)] = 4'h0;
      repeat ($urandom_range(0, 4)) tick();
    end
`ifdef KEYPAD_AUTOREPEAT_EN
    clear_keys();
    repeat (3) tick();
    keys[1] = 4'b0100;
    for (int i = 0; i < 12 && !m_held; i++) tick();
    repeat (16) tick();
`endif
    clear_keys();
    repeat (4) tick();
    repeat (4) @(negedge clk);
    check("pending_events", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
